bf16_bfp_encoder: RTL and testbench
===================================

Name: bf16_bfp_encoder

Overview:
- Streaming front-end that feeds the CIM dot-product datapath.
- Accepts SIZE BF16 operands one per handshake and finds their maximum exponent.
- Converts each operand to an aligned two's-complement mantissa sharing that exponent (block floating point).
- Presents the packed vector plus shared exponent on a valid/ready output: this is the encoder side of the BF16-to-aligned-mantissa conversion the MAC array consumes.

Parameters:
- SIZE, 2, number of BF16 elements per block (>=2).
- MANT_W, 8, output mantissa width (1 sign + hidden 1 + 6 fraction bits); fixed at 8 in this revision.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- in_valid  input  1  BF16 element valid.
- in_ready  output  1  encoder can accept an element.
- in_data  input  16  BF16 element: sign[15], exp[14:7], frac[6:0].
- out_valid  output  1  block result valid.
- out_ready  input  1  downstream accepts block.
- out_exp  output  8  shared (maximum) exponent.
- out_mant  output  8*SIZE  aligned mantissas; element 0 (first accepted) in bits [8*SIZE-1 -: 8].
- out_special  output  1  some element had exp==8'hFF (Inf/NaN).

Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.

Behaviour:
- Reset (async, any state): state=LOAD, count=0, max_exp=0, in_ready=1, out_valid=0, out_exp=0, out_mant=0, out_special=0, buffer cleared.
- States: LOAD, ALIGN, OUT.
- LOAD:
  - in_ready=1. On in_valid&&in_ready: store in_data at buffer[count]; count++.
  - Update max_exp = max(max_exp, in_data exp) for exp!=0.
  - Set special_flag if exp==8'hFF.
  - When the SIZE-th element is accepted: count<=0, go to ALIGN.
- ALIGN:
  - in_ready=0. One element per cycle, index idx = 0..SIZE-1.
  - diff = max_exp - exp[idx]. mag = {1'b1, frac[6:1]} (7 bits) >> diff; logical, truncating; diff>=7 gives 0.
  - exp==0 element: mag=0 (zero/denormal flushed).
  - mant = sign ? (~{1'b0,mag}+1) : {1'b0,mag}, 8-bit; negative zero encodes as 8'h00.
  - After idx=SIZE-1: latch out_exp=max_exp and out_special, go to OUT.
  - Latency: last input accepted at edge k → out_valid high after edge k+SIZE.
- OUT:
  - out_valid=1; out_exp/out_mant/out_special held stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0, max_exp<=0, special cleared, state<=LOAD (in_ready=1 next cycle).
- Error handling:
  - in_valid while in_ready=0 is ignored.
  - out_ready while out_valid=0 is ignored.
- All-zero block: out_exp=0, all mantissas 8'h00.
- Special values: mantissa computed with the ordinary rule (exp 255 is the max); downstream must honour out_special.
- Unsigned exponent compare; max_exp tracks only accepted elements of the current block.
- Reset mid-block discards partial data; no output is produced for that block.

Test Plan:
- SIZE=2, in 0x3F80 (1.0), 0x4000 (2.0) → out_exp=0x80, out_mant=0x20_40, out_special=0, out_valid 2 cycles after second accept.
- in 0xBFC0 (-1.5), 0x3F80 → out_exp=0x7F, out_mant=0xA0_40.
- in 0x3F80, 0x4380 (diff 8) → out_exp=0x87, out_mant=0x00_40; also 0x3F80, 0x4300 (diff 7) → 0x00_40.
- in 0x0000, 0x3F80 → out_exp=0x7F, out_mant=0x00_40. In 0x8000, 0x0000 → out_exp=0, out_mant=0x0000.
- in 0x7F80, 0x3F80 → out_special=1, out_exp=0xFF. Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0. Then accept: in_ready=1 next cycle, and next block 0x3F80, 0x3F80 gives out_exp=0x7F, out_special=0.
- Assert rst_n low after the first element is accepted → all outputs at reset values. Next two elements form a fresh block with a correct result.

Source files
------------

// File: rtl/bf16_bfp_encoder.sv
// ---------------------------------------------------------------------------
// bf16_bfp_encoder
//
// Streaming block-floating-point encoder for the CIM dot-product datapath.
// It collects SIZE BF16 operands, one per valid/ready handshake, and finds
// their largest exponent. It then turns every operand into an 8-bit
// two's-complement mantissa aligned to that shared exponent. The packed
// vector, the shared exponent and an Inf/NaN flag are offered on a
// valid/ready output port.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_in_valid     BF16 element valid
//   o_in_ready     encoder can accept an element (high only while loading)
//   i_in_data      BF16 element: sign[15], exp[14:7], frac[6:0]
//   o_out_valid    block result valid
//   i_out_ready    downstream accepts the block
//   o_out_exp      shared (maximum) exponent
//   o_out_mant     aligned mantissas; element 0 sits in the top byte
//   o_out_special  some element of the block had exp == 8'hFF
// ---------------------------------------------------------------------------
module bf16_bfp_encoder #(
    parameter int SIZE   = 2,
    parameter int MANT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [15:0]              i_in_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [7:0]               o_out_exp,
    output logic [MANT_W*SIZE-1:0]   o_out_mant,
    output logic                     o_out_special
);

    localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ALIGN = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_maxExp;
    logic             r_special;
    // The bottom fraction bit is dropped at capture because the
    // 8-bit mantissa has only 6 fraction bits.
    logic [14:0]      r_buf [SIZE];

    logic             w_accept;
    logic [7:0]       w_inExp;
    logic             w_unused;
    logic [14:0]      w_cur;
    logic             w_sign;
    logic [7:0]       w_exp;
    logic [5:0]       w_frac;
    logic [7:0]       w_diff;
    logic [6:0]       w_mag;
    logic [MANT_W-1:0] w_mant;

    assign w_accept = i_in_valid && o_in_ready;
    assign w_inExp  = i_in_data[14:7];
    assign w_unused = i_in_data[0];

    assign w_cur  = r_buf[r_count];
    assign w_sign = w_cur[14];
    assign w_exp  = w_cur[13:6];
    assign w_frac = w_cur[5:0];
    assign w_diff = r_maxExp - w_exp;

    // Alignment of the element at the current index. Zero and denormal
    // inputs are flushed to zero. A shift of 7 or more empties the 7-bit
    // magnitude, so that case is forced to zero instead of shifted.
    always_comb begin
        w_mag = '0;
        if (w_exp != 8'd0 && w_diff < 8'd7) begin
            w_mag = {1'b1, w_frac} >> w_diff[2:0];
        end
        // Negating a zero magnitude wraps back to 8'h00. This gives the
        // "negative zero encodes as zero" rule without extra logic.
        w_mant = w_sign ? (~{1'b0, w_mag} + 8'd1) : {1'b0, w_mag};
    end

    // Control FSM and datapath registers. In LOAD, elements are captured
    // and the running max exponent is tracked. In ALIGN, one mantissa is
    // converted per cycle straight into the output vector. In OUT, the
    // result is held until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= LOAD;
            r_count       <= '0;
            r_maxExp      <= '0;
            r_special     <= 1'b0;
            o_in_ready    <= 1'b1;
            o_out_valid   <= 1'b0;
            o_out_exp     <= '0;
            o_out_mant    <= '0;
            o_out_special <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_buf[r_count] <= i_in_data[15:1];
                        if (w_inExp != 8'd0 && w_inExp > r_maxExp) begin
                            r_maxExp <= w_inExp;
                        end
                        if (w_inExp == 8'hFF) begin
                            r_special <= 1'b1;
                        end
                        if (r_count == LAST_IDX) begin
                            r_count    <= '0;
                            o_in_ready <= 1'b0;
                            r_state    <= ALIGN;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                ALIGN: begin
                    o_out_mant[MANT_W*(SIZE-1-int'(r_count)) +: MANT_W] <= w_mant;
                    if (r_count == LAST_IDX) begin
                        r_count       <= '0;
                        o_out_exp     <= r_maxExp;
                        o_out_special <= r_special;
                        o_out_valid   <= 1'b1;
                        r_state       <= OUT;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                OUT: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        r_maxExp    <= '0;
                        r_special   <= 1'b0;
                        o_in_ready  <= 1'b1;
                        r_state     <= LOAD;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_bfp_encoder.sv
// ---------------------------------------------------------------------------
// tb_bf16_bfp_encoder
//
// Directed testbench for bf16_bfp_encoder with SIZE=2. The expected
// exponents and mantissas are worked out by hand from the BF16 encodings.
// Inputs are driven on the falling edge. Outputs are sampled on the
// falling edge, away from the active clock edge.
// ---------------------------------------------------------------------------
module tb_bf16_bfp_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_exp;
    logic [15:0] out_mant;
    logic        out_special;

    int total = 0;
    int bad   = 0;

    bf16_bfp_encoder #(.SIZE(2), .MANT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_exp    (out_exp),
        .o_out_mant   (out_mant),
        .o_out_special(out_special)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // The single comparison point: counts the comparison and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Sends two elements back to back. It then leaves in_valid high with
    // Inf data while the encoder is busy; that data must be ignored. The
    // latency is checked as: low one cycle after the last accept, high
    // two cycles after it.
    task automatic applyStimulus(input string name, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        checkOutput({name, " in_ready before load"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = a;
        @(negedge clk);
        in_data  = b;
        @(negedge clk);
        in_data  = 16'h7F80;
        checkOutput({name, " in_ready while aligning"}, in_ready, 0);
        @(negedge clk);
        checkOutput({name, " out_valid one cycle after last"}, out_valid, 0);
        @(negedge clk);
        checkOutput({name, " out_valid two cycles after last"}, out_valid, 1);
        in_valid = 1'b0;
        in_data  = 16'h0000;
    endtask

    // Checks the held result, performs the output handshake, and confirms
    // the return to loading.
    task automatic drainBlock(input string name, input logic [7:0] eExp,
                              input logic [15:0] eMant, input logic eSpec);
        checkOutput({name, " out_exp"}, out_exp, eExp);
        checkOutput({name, " out_mant"}, out_mant, eMant);
        checkOutput({name, " out_special"}, out_special, eSpec);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, " out_valid after accept"}, out_valid, 0);
        checkOutput({name, " in_ready after accept"}, in_ready, 1);
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, " in_ready"}, in_ready, 1);
        checkOutput({name, " out_valid"}, out_valid, 0);
        checkOutput({name, " out_exp"}, out_exp, 8'h00);
        checkOutput({name, " out_mant"}, out_mant, 16'h0000);
        checkOutput({name, " out_special"}, out_special, 0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        // out_ready while nothing is valid must not disturb anything.
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("stray out_ready out_valid", out_valid, 0);
        checkOutput("stray out_ready in_ready", in_ready, 1);

        // 1.0 and 2.0: max exp 0x80, 1.0 shifted by one.
        applyStimulus("one_two", 16'h3F80, 16'h4000);
        drainBlock("one_two", 8'h80, 16'h2040, 1'b0);

        // -1.5 and 1.0: magnitude 0x60 negated gives 0xA0.
        applyStimulus("neg", 16'hBFC0, 16'h3F80);
        drainBlock("neg", 8'h7F, 16'hA040, 1'b0);

        // Exponent gaps of 8 and 7 both flush the smaller operand.
        applyStimulus("diff8", 16'h3F80, 16'h4380);
        drainBlock("diff8", 8'h87, 16'h0040, 1'b0);
        applyStimulus("diff7", 16'h3F80, 16'h4300);
        drainBlock("diff7", 8'h86, 16'h0040, 1'b0);

        // A zero element is flushed and is excluded from the max.
        applyStimulus("zero_one", 16'h0000, 16'h3F80);
        drainBlock("zero_one", 8'h7F, 16'h0040, 1'b0);
        applyStimulus("all_zero", 16'h8000, 16'h0000);
        drainBlock("all_zero", 8'h00, 16'h0000, 1'b0);

        // Inf becomes the max. The result must hold under backpressure.
        applyStimulus("inf", 16'h7F80, 16'h3F80);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold out_valid", out_valid, 1);
            checkOutput("hold in_ready", in_ready, 0);
            checkOutput("hold out_exp", out_exp, 8'hFF);
            checkOutput("hold out_mant", out_mant, 16'h4000);
            checkOutput("hold out_special", out_special, 1);
        end
        drainBlock("inf", 8'hFF, 16'h4000, 1'b1);

        // The special flag and max exponent must not leak into the next block.
        applyStimulus("after_inf", 16'h3F80, 16'h3F80);
        drainBlock("after_inf", 8'h7F, 16'h4040, 1'b0);

        // A reset after one element discards the partial block.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'h0000;
        rst_n    = 1'b0;
        #1;
        checkResetState("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post_reset", 16'h3F80, 16'hBFC0);
        drainBlock("post_reset", 8'h7F, 16'h40A0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
